omi_protocol_monitor: RTL and testbench

Synthesizable, parametrised OMI protocol monitor for NUM_CH independent master/slave channel pairs (CPU↔cache, cache↔memory, …). Each channel runs a per-transaction state machine that tracks the req/rdy handshake, read-beat counting and a progress timeout. Violations are reported through a registered error pulse with channel and code, plus per-channel sticky flags. It sits passively on the buses and is used both in simulation benches and on FPGA debug builds.

---
 rtl/omi_mon_pkg.sv | 25 ++
 rtl/omi_protocol_monitor_ch.sv | 125 ++++++++++++
 rtl/omi_protocol_monitor.sv | 96 +++++++++
 tb/tb_omi_protocol_monitor.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/omi_mon_pkg.sv
// Shared types for the OMI protocol monitor: error codes, channel states and code width.
package omi_mon_pkg;

  localparam int CODE_W = 4;

  typedef enum logic [CODE_W-1:0] {
    ERR_NONE       = 4'd0,
    ERR_REQ_DROP   = 4'd1,
    ERR_UNSTABLE   = 4'd2,
    ERR_MISALIGN   = 4'd3,
    ERR_LEN_RANGE  = 4'd4,
    ERR_VALID_RDY  = 4'd5,
    ERR_DATA_NZ    = 4'd6,
    ERR_EXTRA_BEAT = 4'd7,
    ERR_RDY_DROP   = 4'd8,
    ERR_TIMEOUT    = 4'd9
  } err_code_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RD_DATA = 2'd2
  } ch_state_t;

endpackage

// File: rtl/omi_protocol_monitor_ch.sv
// Single-channel OMI monitor: transaction FSM, beat and progress counters, previous-cycle
// shadows, and a combinational error code (lowest code wins, ERR_NONE when clean).
module omi_ch_monitor
  import omi_mon_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_LEN        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic                    wen,
  input  logic [DATA_WIDTH/8-1:0] ben,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [7:0]              len,
  input  logic                    rdy,
  input  logic                    valid,
  input  logic [DATA_WIDTH-1:0]   rdata,
  output err_code_t               code,
  output logic                    done
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int OFF_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int PROG_W = $clog2(TIMEOUT_CYCLES + 1);

  ch_state_t state, state_next;
  logic [7:0]        beat_cnt;
  logic [7:0]        len_r;
  logic [PROG_W-1:0] prog_cnt;
  logic              prev_ok;

  logic                    req_p1, rdy_p1, acc_p1, wen_p1;
  logic [ADDR_WIDTH-1:0]   addr_p1;
  logic [7:0]              len_p1;
  logic [DATA_WIDTH-1:0]   wdata_p1;
  logic [DATA_WIDTH/8-1:0] ben_p1;

  logic accept, beat, last_beat, progress, active;
  logic misalign, unstable, stall_limit;

  always_comb begin
    accept     = req && rdy && (state != ST_RD_DATA);
    beat       = valid && (state == ST_RD_DATA);
    last_beat  = beat && (beat_cnt == len_r);
    progress   = accept || beat;
    active     = (state != ST_IDLE);
    state_next = state;
    done       = 1'b0;
    case (state)
      ST_IDLE, ST_REQ: begin
        if (accept) begin
          state_next = wen ? ST_IDLE : ST_RD_DATA;
          done       = wen;
        end else if (req) begin
          state_next = ST_REQ;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_RD_DATA: begin
        if (last_beat) begin
          state_next = ST_IDLE;
          done       = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    misalign    = (BYTES > 1) && (addr[OFF_W-1:0] != '0);
    unstable    = (state == ST_REQ) && prev_ok &&
                  ((addr != addr_p1) || (wen != wen_p1) || (len != len_p1) ||
                   (wdata != wdata_p1) || (wen && (ben != ben_p1)));
    // Fires only on the edge that brings the counter to its limit; saturation keeps it single-shot.
    stall_limit = active && !progress && (prog_cnt == PROG_W'(TIMEOUT_CYCLES - 1));
    code        = ERR_NONE;
    if ((state == ST_REQ) && prev_ok && req_p1 && !req) code = ERR_REQ_DROP;
    else if (unstable)                                  code = ERR_UNSTABLE;
    else if (req && misalign)                           code = ERR_MISALIGN;
    else if (req && (len > 8'(MAX_LEN)))                code = ERR_LEN_RANGE;
    else if (valid && rdy)                              code = ERR_VALID_RDY;
    else if (!valid && (rdata != '0))                   code = ERR_DATA_NZ;
    else if (valid && (state != ST_RD_DATA))            code = ERR_EXTRA_BEAT;
    else if (prev_ok && rdy_p1 && !rdy && !acc_p1)      code = ERR_RDY_DROP;
    else if (stall_limit)                               code = ERR_TIMEOUT;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
      prog_cnt <= '0;
      prev_ok  <= 1'b0;
      req_p1   <= 1'b0;
      rdy_p1   <= 1'b0;
      acc_p1   <= 1'b0;
    end else begin
      state   <= state_next;
      prev_ok <= 1'b1;
      req_p1  <= req;
      rdy_p1  <= rdy;
      acc_p1  <= accept;
      if (accept)    beat_cnt <= '0;
      else if (beat) beat_cnt <= beat_cnt + 8'd1;
      if (progress || !active)                         prog_cnt <= '0;
      else if (prog_cnt != PROG_W'(TIMEOUT_CYCLES))    prog_cnt <= prog_cnt + 1'b1;
    end
  end

  // Previous-cycle data copies; prev_ok masks them until the first post-reset sample.
  always_ff @(posedge clk) begin
    wen_p1   <= wen;
    addr_p1  <= addr;
    len_p1   <= len;
    wdata_p1 <= wdata;
    ben_p1   <= ben;
    if (accept) len_r <= len;
  end

endmodule

// File: rtl/omi_protocol_monitor.sv
// OMI protocol monitor top: one omi_ch_monitor per channel, lowest-channel-first error
// selection, and the registered error/done output stage.
module omi_protocol_monitor
  import omi_mon_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_LEN        = 4,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_CH-1:0]              req,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]   addr,
  input  logic [NUM_CH-1:0]              wen,
  input  logic [NUM_CH*DATA_WIDTH/8-1:0] ben,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   wdata,
  input  logic [NUM_CH*8-1:0]            len,
  input  logic [NUM_CH-1:0]              rdy,
  input  logic [NUM_CH-1:0]              valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   rdata,
  output logic                           err_valid,
  output logic [CH_W-1:0]                err_ch,
  output logic [CODE_W-1:0]              err_code,
  output logic [NUM_CH-1:0]              err_sticky,
  output logic [NUM_CH-1:0]              txn_done
);

  localparam int BYTES = DATA_WIDTH / 8;

  err_code_t         ch_code [NUM_CH];
  logic [NUM_CH-1:0] ch_done;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    omi_ch_monitor #(
      .ADDR_WIDTH    (ADDR_WIDTH),
      .DATA_WIDTH    (DATA_WIDTH),
      .MAX_LEN       (MAX_LEN),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_ch (
      .clk    (clk),
      .reset_n(reset_n),
      .req    (req[c]),
      .addr   (addr[c*ADDR_WIDTH +: ADDR_WIDTH]),
      .wen    (wen[c]),
      .ben    (ben[c*BYTES +: BYTES]),
      .wdata  (wdata[c*DATA_WIDTH +: DATA_WIDTH]),
      .len    (len[c*8 +: 8]),
      .rdy    (rdy[c]),
      .valid  (valid[c]),
      .rdata  (rdata[c*DATA_WIDTH +: DATA_WIDTH]),
      .code   (ch_code[c]),
      .done   (ch_done[c])
    );
  end

  logic              hit;
  logic [CH_W-1:0]   hit_ch;
  err_code_t         hit_code;
  logic [NUM_CH-1:0] hit_flags;

  // Scan from the top channel down so the lowest erroring index is the one left selected.
  always_comb begin
    hit       = 1'b0;
    hit_ch    = '0;
    hit_code  = ERR_NONE;
    hit_flags = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (ch_code[c] != ERR_NONE) begin
        hit          = 1'b1;
        hit_ch       = CH_W'(c);
        hit_code     = ch_code[c];
        hit_flags[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_valid  <= 1'b0;
      err_ch     <= '0;
      err_code   <= '0;
      err_sticky <= '0;
      txn_done   <= '0;
    end else begin
      err_valid  <= hit;
      err_ch     <= hit_ch;
      err_code   <= hit_code;
      err_sticky <= err_sticky | hit_flags;
      txn_done   <= ch_done;
    end
  end

endmodule

// File: tb/tb_omi_protocol_monitor.sv
// Directed bench for omi_protocol_monitor (2 channels, TIMEOUT_CYCLES=8) with hand-computed expectations.
module tb_omi_protocol_monitor;

  localparam int NUM_CH = 2;
  localparam int AW     = 10;
  localparam int DW     = 32;
  localparam int BW     = DW / 8;
  localparam int MAXL   = 4;
  localparam int TO     = 8;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [NUM_CH-1:0]    req, wen, rdy, valid;
  logic [NUM_CH*AW-1:0] addr;
  logic [NUM_CH*BW-1:0] ben;
  logic [NUM_CH*DW-1:0] wdata, rdata;
  logic [NUM_CH*8-1:0]  len;
  logic                 err_valid;
  logic [0:0]           err_ch;
  logic [3:0]           err_code;
  logic [NUM_CH-1:0]    err_sticky, txn_done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  omi_protocol_monitor #(
    .NUM_CH(NUM_CH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LEN(MAXL), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .addr(addr), .wen(wen), .ben(ben),
    .wdata(wdata), .len(len), .rdy(rdy), .valid(valid), .rdata(rdata),
    .err_valid(err_valid), .err_ch(err_ch), .err_code(err_code),
    .err_sticky(err_sticky), .txn_done(txn_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req = '0; addr = '0; wen = '0; ben = '0; wdata = '0;
    len = '0; rdy = '0; valid = '0; rdata = '0;
  endtask

  task automatic drive_req(input int c, input logic r, input logic [AW-1:0] a,
                           input logic w, input logic [7:0] l, input logic rd);
    req[c]           = r;
    addr[c*AW +: AW] = a;
    wen[c]           = w;
    len[c*8 +: 8]    = l;
    rdy[c]           = rd;
    ben[c*BW +: BW]  = w ? {BW{1'b1}} : {BW{1'b0}};
    wdata[c*DW +: DW] = w ? 32'hCAFE_F00D : 32'h0;
  endtask

  task automatic drive_beat(input int c, input logic v, input logic [DW-1:0] d);
    valid[c]          = v;
    rdata[c*DW +: DW] = v ? d : '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  int n_err, first_idx;
  logic [3:0] seen_code;
  logic [0:0] seen_ch;

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    step();
    step();
    chk("rst_err_valid", err_valid, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_err_ch", err_ch, 0);
    chk("rst_sticky", err_sticky, 0);
    chk("rst_txn_done", txn_done, 0);
    reset_n = 1'b1;
    step();
    chk("post_rst_quiet", err_valid, 0);

    // Ch0 read, len 3, four beats with one gap cycle
    drive_req(0, 1, 10'h010, 0, 8'd3, 1);
    step();
    chk("t1_accept_quiet", err_valid, 0);
    chk("t1_accept_no_done", txn_done, 0);
    drive_req(0, 0, 10'h010, 0, 8'd3, 0);
    drive_beat(0, 1, 32'hA0);
    step();
    drive_beat(0, 0, 32'h0);
    step();
    drive_beat(0, 1, 32'hA1);
    step();
    drive_beat(0, 1, 32'hA2);
    step();
    chk("t1_third_beat_no_done", txn_done, 0);
    drive_beat(0, 1, 32'hA3);
    step();
    chk("t1_done", txn_done, 2'b01);
    chk("t1_last_quiet", err_valid, 0);
    drive_beat(0, 0, 32'h0);
    step();
    chk("t1_done_pulse", txn_done, 0);
    chk("t1_sticky_clean", err_sticky, 0);

    // Ch1 write request whose address changes before rdy
    drive_req(1, 1, 10'h020, 1, 8'd0, 0);
    step();
    chk("t2_req_quiet", err_valid, 0);
    drive_req(1, 1, 10'h024, 1, 8'd0, 0);
    step();
    chk("t2_err_valid", err_valid, 1);
    chk("t2_err_ch", err_ch, 1);
    chk("t2_err_code", err_code, 2);
    chk("t2_sticky", err_sticky, 2'b10);
    drive_req(1, 1, 10'h024, 1, 8'd0, 1);
    step();
    chk("t2_write_done", txn_done, 2'b10);
    chk("t2_accept_quiet", err_valid, 0);
    drive_req(1, 0, 10'h000, 0, 8'd0, 0);
    step();
    chk("t2_release_quiet", err_valid, 0);
    do_reset();
    chk("reset_clears_sticky", err_sticky, 0);

    // Misaligned address and out-of-range len together: lowest code reported
    drive_req(0, 1, 10'h006, 0, 8'd5, 0);
    step();
    chk("t3_err_valid", err_valid, 1);
    chk("t3_err_ch", err_ch, 0);
    chk("t3_err_code", err_code, 3);
    chk("t3_sticky", err_sticky, 2'b01);
    do_reset();

    // Ch0 read len 1, slave delivers three beats
    drive_req(0, 1, 10'h000, 0, 8'd1, 1);
    step();
    chk("t4_accept_quiet", err_valid, 0);
    drive_req(0, 0, 10'h000, 0, 8'd1, 0);
    drive_beat(0, 1, 32'h11);
    step();
    chk("t4_beat1_quiet", err_valid, 0);
    drive_beat(0, 1, 32'h22);
    step();
    chk("t4_done", txn_done, 2'b01);
    chk("t4_beat2_quiet", err_valid, 0);
    drive_beat(0, 1, 32'h33);
    step();
    chk("t4_err_valid", err_valid, 1);
    chk("t4_err_ch", err_ch, 0);
    chk("t4_err_code", err_code, 7);
    drive_beat(0, 0, 32'h0);
    step();
    chk("t4_pulse_ends", err_valid, 0);
    do_reset();

    // Ch0 REQ_DROP and ch1 VALID_RDY on the same edge
    drive_req(0, 1, 10'h008, 0, 8'd0, 0);
    step();
    chk("t5_req_quiet", err_valid, 0);
    drive_req(0, 0, 10'h008, 0, 8'd0, 0);
    rdy[1] = 1'b1;
    drive_beat(1, 1, 32'h55);
    step();
    chk("t5_err_valid", err_valid, 1);
    chk("t5_err_ch", err_ch, 0);
    chk("t5_err_code", err_code, 1);
    chk("t5_sticky", err_sticky, 2'b11);
    do_reset();

    // Ch1 read accepted, no beats: single TIMEOUT after TO stalled edges, then reset mid-stall
    drive_req(1, 1, 10'h040, 0, 8'd2, 1);
    step();
    chk("t6_accept_quiet", err_valid, 0);
    drive_req(1, 0, 10'h040, 0, 8'd2, 0);
    n_err = 0;
    first_idx = 0;
    seen_code = '0;
    seen_ch = '0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (err_valid) begin
        n_err++;
        if (first_idx == 0) first_idx = i;
        seen_code = err_code;
        seen_ch = err_ch;
      end
    end
    chk("t6_timeout_count", n_err, 1);
    chk("t6_timeout_cycle", first_idx, TO);
    chk("t6_timeout_code", seen_code, 9);
    chk("t6_timeout_ch", seen_ch, 1);
    chk("t6_sticky", err_sticky, 2'b10);
    reset_n = 1'b0;
    step();
    chk("t6_rst_err_valid", err_valid, 0);
    chk("t6_rst_err_code", err_code, 0);
    chk("t6_rst_err_ch", err_ch, 0);
    chk("t6_rst_sticky", err_sticky, 0);
    chk("t6_rst_txn_done", txn_done, 0);
    reset_n = 1'b1;
    step();
    step();
    chk("t6_after_rst_quiet", err_valid, 0);

    // Boundary lengths: ch0 len = MAX_LEN (5 beats), ch1 len = 0 (single beat)
    drive_req(0, 1, 10'h000, 0, 8'd4, 1);
    drive_req(1, 1, 10'h3FC, 0, 8'd0, 1);
    step();
    chk("t7_accept_quiet", err_valid, 0);
    drive_req(0, 0, 10'h000, 0, 8'd4, 0);
    drive_req(1, 0, 10'h3FC, 0, 8'd0, 0);
    drive_beat(1, 1, 32'h77);
    step();
    chk("t7_len0_done", txn_done, 2'b10);
    chk("t7_len0_quiet", err_valid, 0);
    drive_beat(1, 0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      drive_beat(0, 1, 32'(i + 1));
      step();
    end
    chk("t7_maxlen_done", txn_done, 2'b01);
    chk("t7_maxlen_quiet", err_valid, 0);
    drive_beat(0, 0, 32'h0);
    step();
    chk("t7_sticky_clean", err_sticky, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
